compcount_feeder: RTL and testbench

//   Upstream stage of the comparator counter. Accepts 16-bit keys from the

---
 rtl/compcount_feeder.sv | 76 +++++++
 tb/tb_compcount_feeder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compcount_feeder.sv
// Reduces accepted keys to bytes, buffers them in a DEPTH-entry FIFO and streams one per cycle on din/enb.
// Key accepted at edge N reaches din/enb after edge N+1; key_ready drops when full or in reset, hold stalls pops.
module compcount_feeder #(
  parameter int KEY_W = 16,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_W-1:0]           key_in,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic                       hold,
  output logic [7:0]                 din,
  output logic                       enb,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    sample;
  logic          push;
  logic          pop;

  always_comb begin
    sample = key_in[7:0];
    case (MODE)
      1:       sample = key_in[15:8];
      2:       sample = (key_in[15:8] != 8'h00) ? 8'hFF : key_in[7:0];
      default: sample = key_in[7:0];
    endcase
  end

  // Ready looks only at the registered level, so a pop in the same cycle never frees a slot early.
  assign key_ready = (level < FULL) && !rst;
  assign push      = key_valid && key_ready;
  assign pop       = (level != '0) && !hold;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      din    <= 8'h00;
      enb    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        din    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
        enb    <= 1'b1;
      end else begin
        enb    <= 1'b0;
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_compcount_feeder.sv
// Bench for compcount_feeder: one instance per reduction mode, all fed the same stimulus and checked against a key-queue model.
module tb_compcount_feeder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        hold;
  logic [15:0] key_in;

  logic        rdy   [3];
  logic        enb_a [3];
  logic [7:0]  din_a [3];
  logic [2:0]  lvl   [3];

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted keys, last popped key, expected enb.
  logic [15:0] kq [$];
  logic [15:0] m_key;
  logic        m_enb;
  logic [15:0] pend [$];
  logic [7:0]  seen [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    compcount_feeder #(.KEY_W(16), .DEPTH(DEPTH), .MODE(g)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (rdy[g]),
      .hold      (hold),
      .din       (din_a[g]),
      .enb       (enb_a[g]),
      .level     (lvl[g])
    );
  end

  function automatic logic [7:0] reduce(input logic [15:0] k, input int mode);
    if (mode == 0) return k[7:0];
    if (mode == 1) return k[15:8];
    return (k[15:8] != 8'h00) ? 8'hFF : k[7:0];
  endfunction

  function automatic logic exp_ready();
    return !rst && (kq.size() < DEPTH);
  endfunction

  // Advances the model across one rising edge; returns whether the offered key was taken.
  task automatic tick(output logic acc);
    logic do_pop;
    acc    = key_valid && exp_ready();
    do_pop = !rst && (kq.size() > 0) && !hold;
    @(posedge clk);
    if (rst) begin
      kq.delete();
      m_key = 16'h0000;
      m_enb = 1'b0;
    end else begin
      if (do_pop) begin
        m_key = kq.pop_front();
        m_enb = 1'b1;
      end else begin
        m_enb = 1'b0;
      end
      if (acc) kq.push_back(key_in);
    end
    #1;
  endtask

  task automatic offer_pending();
    key_valid = (pend.size() > 0);
    key_in    = (pend.size() > 0) ? pend[0] : 16'($urandom);
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b1; key_valid = 1'b1; hold = 1'b0;
    for (int c = 0; c < 10; c++) begin
      key_in = 16'($urandom);
      #1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rdy[m] !== 1'b0) begin
          errors++; $display("FAIL reset_ready mode%0d cyc%0d: got %b want 0", m, c, rdy[m]);
        end
      end
      tick(acc);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== 1'b0 || lvl[m] !== 3'd0 || din_a[m] !== 8'h00) begin
          errors++;
          $display("FAIL reset_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=0 level=0 din=00",
                   m, c, enb_a[m], lvl[m], din_a[m]);
        end
      end
    end
    rst = 1'b0; key_valid = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   acc_cyc = -1;
    int   first_enb = -1;
    pend = '{16'h1201, 16'h3405};
    seen.delete();
    for (int c = 0; c < 6; c++) begin
      offer_pending();
      #1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rdy[m] !== exp_ready()) begin
          errors++; $display("FAIL b2b_ready mode%0d cyc%0d: got %b want %b", m, c, rdy[m], exp_ready());
        end
      end
      tick(acc);
      if (acc) begin
        if (acc_cyc < 0) acc_cyc = c;
        void'(pend.pop_front());
      end
      if (enb_a[0] === 1'b1) begin
        seen.push_back(din_a[0]);
        if (first_enb < 0) first_enb = c;
      end
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL b2b_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 8'h01 || seen[1] !== 8'h05) begin
      errors++; $display("FAIL b2b_seq: got %0d samples %p want 01,05", seen.size(), seen);
    end
    checks++;
    if (first_enb != acc_cyc + 1) begin
      errors++; $display("FAIL b2b_latency: first enb cycle %0d want %0d", first_enb, acc_cyc + 1);
    end
    checks++;
    if (lvl[0] !== 3'd0) begin
      errors++; $display("FAIL b2b_level: got %0d want 0", lvl[0]);
    end
  endtask

  task automatic test_hold_full();
    logic        acc;
    logic [15:0] keys [$];
    logic [7:0]  want [$];
    hold = 1'b1;
    pend.delete();
    for (int i = 0; i < 5; i++) pend.push_back(16'($urandom));
    keys = pend;
    for (int i = 0; i < 5; i++) want.push_back(reduce(keys[i], 0));
    for (int c = 0; c < 8; c++) begin
      offer_pending();
      #1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rdy[m] !== exp_ready()) begin
          errors++; $display("FAIL hold_ready mode%0d cyc%0d: got %b want %b", m, c, rdy[m], exp_ready());
        end
      end
      tick(acc);
      if (acc) void'(pend.pop_front());
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL hold_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    checks++;
    if (lvl[0] !== 3'd4 || rdy[0] !== 1'b0 || pend.size() != 1 || enb_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_full: level=%0d ready=%b pending=%0d enb=%b want level=4 ready=0 pending=1 enb=0",
               lvl[0], rdy[0], pend.size(), enb_a[0]);
    end
    hold = 1'b0;
    seen.delete();
    for (int c = 0; c < 8; c++) begin
      offer_pending();
      #1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rdy[m] !== exp_ready()) begin
          errors++; $display("FAIL drain_ready mode%0d cyc%0d: got %b want %b", m, c, rdy[m], exp_ready());
        end
      end
      tick(acc);
      if (acc) void'(pend.pop_front());
      if (enb_a[0] === 1'b1) seen.push_back(din_a[0]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL drain_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    checks++;
    if (seen != want) begin
      errors++; $display("FAIL drain_order: got %p want %p", seen, want);
    end
  endtask

  task automatic test_mode2();
    logic       acc;
    logic [7:0] sat [$];
    logic [7:0] hi  [$];
    pend = '{16'h0008, 16'h0102, 16'h00FF};
    for (int c = 0; c < 6; c++) begin
      offer_pending();
      #1;
      tick(acc);
      if (acc) void'(pend.pop_front());
      if (enb_a[2] === 1'b1) sat.push_back(din_a[2]);
      if (enb_a[1] === 1'b1) hi.push_back(din_a[1]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL mode2_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    checks++;
    if (sat.size() != 3 || sat[0] !== 8'h08 || sat[1] !== 8'hFF || sat[2] !== 8'hFF) begin
      errors++; $display("FAIL mode2_seq: got %p want 08,FF,FF", sat);
    end
    checks++;
    if (hi.size() != 3 || hi[0] !== 8'h00 || hi[1] !== 8'h01 || hi[2] !== 8'h00) begin
      errors++; $display("FAIL mode1_seq: got %p want 00,01,00", hi);
    end
  endtask

  task automatic test_stream();
    logic acc;
    int   stalls = 0;
    int   max_lvl = 0;
    logic [7:0] first_hi = 8'h00;
    pend.delete();
    pend.push_back(16'hAB00);
    for (int i = 0; i < 30; i++) pend.push_back(16'($urandom));
    for (int c = 0; c < 31; c++) begin
      offer_pending();
      #1;
      if (rdy[1] !== 1'b1) stalls++;
      tick(acc);
      if (acc) void'(pend.pop_front());
      if (c == 1) first_hi = din_a[1];
      if (c >= 1 && enb_a[1] !== 1'b1) stalls++;
      if (int'(lvl[1]) > max_lvl) max_lvl = int'(lvl[1]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL stream_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    checks++;
    if (stalls != 0 || max_lvl > 1 || first_hi !== 8'hAB) begin
      errors++;
      $display("FAIL stream_rate: stalls=%0d max_level=%0d first=%h want stalls=0 max_level<=1 first=AB",
               stalls, max_lvl, first_hi);
    end
    key_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick(acc);
  endtask

  task automatic test_reset_mid();
    logic acc;
    int   late = 0;
    hold = 1'b1;
    pend = '{16'h1111, 16'h2222, 16'h3333};
    for (int c = 0; c < 4; c++) begin
      offer_pending();
      #1;
      tick(acc);
      if (acc) void'(pend.pop_front());
    end
    checks++;
    if (lvl[0] !== 3'd3) begin
      errors++; $display("FAIL midrst_fill: level=%0d want 3", lvl[0]);
    end
    rst = 1'b1; key_valid = 1'b0;
    #1;
    tick(acc);
    rst = 1'b0; hold = 1'b0;
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (lvl[m] !== 3'd0 || enb_a[m] !== 1'b0 || din_a[m] !== 8'h00) begin
        errors++;
        $display("FAIL midrst_out mode%0d: level=%0d enb=%b din=%h want level=0 enb=0 din=00",
                 m, lvl[m], enb_a[m], din_a[m]);
      end
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      tick(acc);
      for (int m = 0; m < 3; m++) if (enb_a[m] !== 1'b0 || din_a[m] !== 8'h00) late++;
    end
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL midrst_stale: %0d cycles showed old data, want 0", late);
    end
  endtask

  task automatic test_random();
    logic acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!key_valid || acc) begin
        key_valid = ($urandom_range(0, 9) < 7);
        key_in    = ($urandom_range(0, 1) == 1) ? {8'h00, 8'($urandom)} : 16'($urandom);
      end
      hold = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      #1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rdy[m] !== exp_ready()) begin
          errors++; $display("FAIL rand_ready mode%0d cyc%0d: got %b want %b", m, c, rdy[m], exp_ready());
        end
      end
      tick(acc);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (enb_a[m] !== m_enb || lvl[m] !== 3'(kq.size()) || din_a[m] !== reduce(m_key, m)) begin
          errors++;
          $display("FAIL rand_out mode%0d cyc%0d: enb=%b level=%0d din=%h want enb=%b level=%0d din=%h",
                   m, c, enb_a[m], lvl[m], din_a[m], m_enb, kq.size(), reduce(m_key, m));
        end
      end
    end
    rst = 1'b0; hold = 1'b0; key_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; hold = 1'b0; key_in = 16'h0000;
    m_key = 16'h0000; m_enb = 1'b0;
    test_reset();
    test_back_to_back();
    test_hold_full();
    test_mode2();
    test_stream();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
